// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between the lab6 data path and the 8-digit seven-segment scanner.
// The master supplies the value and masks; the slave drives the board's display lines.
interface seg7_scan_ctrl_if;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        DP;
  logic        frame_tick;

  modport master (
    output data, dp_mask, digit_en, lz_blank,
    input  anode, cathode, DP, frame_tick
  );

  modport slave (
    input  data, dp_mask, digit_en, lz_blank,
    output anode, cathode, DP, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scanner with an anti-ghosting blanking gap
// between digits and a once-per-frame snapshot of the displayed value.
module seg7_scan_ctrl #(
  parameter int DIV     = 100000,
  parameter int GAP_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic {S_GAP, S_DRIVE} state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [PW-1:0]   pre_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic [31:0]     snap_q;
  logic [7:0]      dp_s_q;
  logic [7:0]      en_s_q;
  logic            lz_s_q;
  logic            frame_tick_q;
  logic [7:0]      anode_q;
  logic [6:0]      cathode_q;
  logic            dp_q;

  logic [3:0]      nib_d;
  logic [31:0]     upper_d;
  logic            lzb_d;
  logic            lit_d;
  logic [7:0]      anode_d;
  logic [6:0]      cathode_d;
  logic            dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Leading-zero test: everything from the current nibble upward is zero.
  always_comb begin
    nib_d     = snap_q[{idx_q, 2'b00} +: 4];
    upper_d   = snap_q >> {idx_q, 2'b00};
    lzb_d     = lz_s_q && (idx_q != 3'd0) && (upper_d == 32'd0);
    lit_d     = (state_q == S_DRIVE) && en_s_q[idx_q] && !lzb_d;
    cathode_d = lit_d ? hex7(nib_d) : 7'h7F;
    dp_d      = lit_d ? ~dp_s_q[idx_q] : 1'b1;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_anode
    assign anode_d[gi] = !(lit_d && (idx_q == 3'(gi)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_GAP;
      idx_q        <= 3'd0;
      pre_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      snap_q       <= 32'd0;
      dp_s_q       <= 8'd0;
      en_s_q       <= 8'd0;
      lz_s_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      anode_q      <= 8'hFF;
      cathode_q    <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      frame_tick_q <= 1'b0;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      dp_q         <= dp_d;
      case (state_q)
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q   <= S_DRIVE;
            gap_cnt_q <= '0;
            pre_cnt_q <= '0;
            // Only the start of digit 0 samples inputs, so a frame never tears.
            if (idx_q == 3'd0) begin
              snap_q       <= bus.data;
              dp_s_q       <= bus.dp_mask;
              en_s_q       <= bus.digit_en;
              lz_s_q       <= bus.lz_blank;
              frame_tick_q <= 1'b1;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: begin
          if (pre_cnt_q == PRE_LAST) begin
            state_q   <= S_GAP;
            idx_q     <= idx_q + 3'd1;
            pre_cnt_q <= '0;
            gap_cnt_q <= '0;
          end else begin
            pre_cnt_q <= pre_cnt_q + PW'(1);
          end
        end
      endcase
    end
  end

  assign bus.anode      = anode_q;
  assign bus.cathode    = cathode_q;
  assign bus.DP         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
